// File: rtl/lsu_mem_arbiter_if.sv
// lsu_mem_arbiter_if: LSU-side request/response and memory-channel buses of the arbiter.
interface lsu_mem_arbiter_if #(
   parameter int NUM_LSUS     = 4,
   parameter int NUM_CHANNELS = 2,
   parameter int ADDR_BITS    = 8,
   parameter int DATA_BITS    = 32
);
   logic [NUM_LSUS-1:0]                    lsu_valid;
   logic [NUM_LSUS-1:0][ADDR_BITS-1:0]     lsu_addr;
   logic [NUM_LSUS-1:0][DATA_BITS-1:0]     lsu_data;
   logic [NUM_LSUS-1:0]                    lsu_we;
   logic [NUM_LSUS-1:0]                    lsu_resp_ready;
   logic [NUM_LSUS-1:0][DATA_BITS-1:0]     lsu_resp_data;
   logic [NUM_CHANNELS-1:0]                mem_req_valid;
   logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_req_addr;
   logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_req_data;
   logic [NUM_CHANNELS-1:0]                mem_req_we;
   logic [NUM_CHANNELS-1:0]                mem_req_ready;
   logic [NUM_CHANNELS-1:0]                mem_resp_valid;
   logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_resp_data;
   modport master (
      input  lsu_valid, lsu_addr, lsu_data, lsu_we, mem_req_ready, mem_resp_valid, mem_resp_data,
      output lsu_resp_ready, lsu_resp_data, mem_req_valid, mem_req_addr, mem_req_data, mem_req_we
   );
   modport slave (
      output lsu_valid, lsu_addr, lsu_data, lsu_we, mem_req_ready, mem_resp_valid, mem_resp_data,
      input  lsu_resp_ready, lsu_resp_data, mem_req_valid, mem_req_addr, mem_req_data, mem_req_we
   );
endinterface

// File: rtl/lsu_mem_arbiter.sv
// lsu_mem_arbiter: round-robin sharing of memory channels among per-thread LSUs, responses routed to the issuing LSU.
module lsu_mem_arbiter #(
   parameter int NUM_LSUS     = 4,
   parameter int NUM_CHANNELS = 2,
   parameter int ADDR_BITS    = 8,
   parameter int DATA_BITS    = 32
) (
   input  logic               clk,
   input  logic               reset,
   lsu_mem_arbiter_if.master  bus
);
   localparam int LW = NUM_LSUS > 1 ? $clog2(NUM_LSUS) : 1;
   typedef enum logic [1:0] {CH_IDLE, CH_REQ, CH_WAIT} ch_state_e;
   ch_state_e                              st_q [NUM_CHANNELS];
   ch_state_e                              st_d [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0][LW-1:0]        own_q, own_d;
   logic [NUM_LSUS-1:0]                    served_q, served_d, granted;
   logic [LW-1:0]                          rr_q, rr_d;
   logic [NUM_CHANNELS-1:0]                req_valid_q, req_valid_d, req_we_q, req_we_d;
   logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] req_addr_q, req_addr_d;
   logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] req_data_q, req_data_d;
   logic [NUM_LSUS-1:0]                    resp_ready_q, resp_ready_d;
   logic [NUM_LSUS-1:0][DATA_BITS-1:0]     resp_data_q, resp_data_d;
   logic [NUM_CHANNELS-1:0]                free;
   logic [LW-1:0]                          idx;
   logic                                   taken;
   always_comb begin
      st_d         = st_q;
      own_d        = own_q;
      rr_d         = rr_q;
      req_valid_d  = req_valid_q;
      req_we_d     = req_we_q;
      req_addr_d   = req_addr_q;
      req_data_d   = req_data_q;
      resp_ready_d = '0;
      resp_data_d  = resp_data_q;
      granted      = '0;
      free         = '0;
      idx          = '0;
      taken        = 1'b0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         free[c] = st_q[c] == CH_IDLE;
         if (st_q[c] == CH_REQ && bus.mem_req_ready[c]) begin
            req_valid_d[c] = 1'b0;
            st_d[c]       = CH_WAIT;
         end
         if (st_q[c] == CH_WAIT && bus.mem_resp_valid[c]) begin
            resp_ready_d[own_q[c]] = 1'b1;
            resp_data_d[own_q[c]]  = bus.mem_resp_data[c];
            st_d[c]               = CH_IDLE;
         end
      end
      // k-th eligible LSU from rr_q takes the k-th lowest idle channel
      for (int k = 0; k < NUM_LSUS; k++) begin
         idx   = LW'((int'(rr_q) + k) % NUM_LSUS);
         taken = 1'b0;
         if (bus.lsu_valid[idx] && !served_q[idx])
            for (int c = 0; c < NUM_CHANNELS; c++)
               if (!taken && free[c]) begin
                  free[c]        = 1'b0;
                  taken          = 1'b1;
                  st_d[c]        = CH_REQ;
                  own_d[c]       = idx;
                  req_valid_d[c] = 1'b1;
                  req_addr_d[c]  = bus.lsu_addr[idx];
                  req_data_d[c]  = bus.lsu_data[idx];
                  req_we_d[c]    = bus.lsu_we[idx];
                  granted[idx]   = 1'b1;
                  rr_d           = LW'((int'(idx) + 1) % NUM_LSUS);
               end
      end
      // a held-high request stays served until its valid drops
      served_d = (served_q | granted) & bus.lsu_valid;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         for (int c = 0; c < NUM_CHANNELS; c++) st_q[c] <= CH_IDLE;
         own_q        <= '0;
         rr_q         <= '0;
         served_q     <= '0;
         req_valid_q  <= '0;
         req_we_q     <= '0;
         req_addr_q   <= '0;
         req_data_q   <= '0;
         resp_ready_q <= '0;
         resp_data_q  <= '0;
      end else begin
         st_q         <= st_d;
         own_q        <= own_d;
         rr_q         <= rr_d;
         served_q     <= served_d;
         req_valid_q  <= req_valid_d;
         req_we_q     <= req_we_d;
         req_addr_q   <= req_addr_d;
         req_data_q   <= req_data_d;
         resp_ready_q <= resp_ready_d;
         resp_data_q  <= resp_data_d;
      end
   assign bus.mem_req_valid  = req_valid_q;
   assign bus.mem_req_addr   = req_addr_q;
   assign bus.mem_req_data   = req_data_q;
   assign bus.mem_req_we     = req_we_q;
   assign bus.lsu_resp_ready = resp_ready_q;
   assign bus.lsu_resp_data  = resp_data_q;
endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// tb_lsu_mem_arbiter: random LSU/memory traffic against a queue-based reference of the arbiter rules.
module tb_lsu_mem_arbiter;
   localparam int NL = 4, NC = 2, AB = 8, DB = 32;
   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0, n_err = 0;
   lsu_mem_arbiter_if #(.NUM_LSUS(NL), .NUM_CHANNELS(NC), .ADDR_BITS(AB), .DATA_BITS(DB)) bus ();
   lsu_mem_arbiter #(.NUM_LSUS(NL), .NUM_CHANNELS(NC), .ADDR_BITS(AB), .DATA_BITS(DB)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );
   always #5 clk = ~clk;
   // reference: channel phase 0=free 1=requesting 2=awaiting response
   int                  ph [NC];
   int                  own [NC];
   bit                  served [NL];
   int                  rr;
   logic [NC-1:0]         e_mv, e_mwe;
   logic [NC-1:0][AB-1:0] e_ma;
   logic [NC-1:0][DB-1:0] e_md;
   logic [NL-1:0]         e_rr;
   logic [NL-1:0][DB-1:0] e_rd;
   int                  hold [NL];
   bit                  done [NL];
   task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask
   task automatic check_outputs(input string tag);
      chk({tag, ".mem_req_valid"}, 256'(bus.mem_req_valid), 256'(e_mv));
      chk({tag, ".mem_req_addr"}, 256'(bus.mem_req_addr), 256'(e_ma));
      chk({tag, ".mem_req_data"}, 256'(bus.mem_req_data), 256'(e_md));
      chk({tag, ".mem_req_we"}, 256'(bus.mem_req_we), 256'(e_mwe));
      chk({tag, ".lsu_resp_ready"}, 256'(bus.lsu_resp_ready), 256'(e_rr));
      chk({tag, ".lsu_resp_data"}, 256'(bus.lsu_resp_data), 256'(e_rd));
   endtask
   task automatic model_reset();
      for (int c = 0; c < NC; c++) begin ph[c] = 0; own[c] = 0; end
      for (int i = 0; i < NL; i++) served[i] = 0;
      rr = 0;
      e_mv = '0; e_mwe = '0; e_ma = '0; e_md = '0; e_rr = '0; e_rd = '0;
   endtask
   task automatic model_step();
      int idle_q[$];
      int elig_q[$];
      int n, c, i;
      for (int k = 0; k < NC; k++) if (ph[k] == 0) idle_q.push_back(k);
      for (int k = 0; k < NL; k++) begin
         i = (rr + k) % NL;
         if (bus.lsu_valid[i] && !served[i]) elig_q.push_back(i);
      end
      e_rr = '0;
      for (int k = 0; k < NC; k++)
         if (ph[k] == 1 && bus.mem_req_ready[k]) begin
            ph[k] = 2;
            e_mv[k] = 1'b0;
         end else if (ph[k] == 2 && bus.mem_resp_valid[k]) begin
            e_rr[own[k]] = 1'b1;
            e_rd[own[k]] = bus.mem_resp_data[k];
            ph[k] = 0;
         end
      n = idle_q.size() < elig_q.size() ? idle_q.size() : elig_q.size();
      for (int j = 0; j < n; j++) begin
         c = idle_q[j];
         i = elig_q[j];
         ph[c] = 1;
         own[c] = i;
         e_mv[c] = 1'b1;
         e_ma[c] = bus.lsu_addr[i];
         e_md[c] = bus.lsu_data[i];
         e_mwe[c] = bus.lsu_we[i];
         served[i] = 1;
         rr = (i + 1) % NL;
      end
      for (int k = 0; k < NL; k++) if (!bus.lsu_valid[k]) served[k] = 0;
   endtask
   task automatic drive(input int p_ready);
      for (int i = 0; i < NL; i++)
         if (bus.lsu_valid[i]) begin
            if (e_rr[i]) begin
               done[i] = 1;
               hold[i] = $urandom_range(0, 3);
            end
            if (done[i]) begin
               if (hold[i] == 0) begin
                  bus.lsu_valid[i] = 1'b0;
                  done[i] = 0;
               end else hold[i]--;
            end
         end else if ($urandom_range(0, 1) == 1) begin
            bus.lsu_valid[i] = 1'b1;
            bus.lsu_addr[i]  = AB'($urandom);
            bus.lsu_data[i]  = $urandom;
            bus.lsu_we[i]    = 1'($urandom_range(0, 1));
         end
      for (int c = 0; c < NC; c++) begin
         bus.mem_req_ready[c]  = $urandom_range(0, 99) < p_ready;
         bus.mem_resp_valid[c] = $urandom_range(0, 2) == 0;
         bus.mem_resp_data[c]  = $urandom;
      end
   endtask
   task automatic clear_lsus();
      bus.lsu_valid = '0;
      for (int i = 0; i < NL; i++) begin done[i] = 0; hold[i] = 0; end
   endtask
   initial begin
      reset = 1'b1;
      bus.lsu_valid = '0; bus.lsu_addr = '0; bus.lsu_data = '0; bus.lsu_we = '0;
      bus.mem_req_ready = '0; bus.mem_resp_valid = '0; bus.mem_resp_data = '0;
      clear_lsus();
      model_reset();
      repeat (2) @(negedge clk);
      check_outputs("reset");
      reset = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (cyc > 0) begin
            @(negedge clk);
            check_outputs(cyc < 1000 ? "run" : cyc < 2000 ? "backpressure" : "post_reset");
         end
         if (cyc == 2000) begin
            reset = 1'b1;
            #1;
            model_reset();
            check_outputs("async_reset");
            clear_lsus();
            bus.mem_req_ready = '1;
            bus.mem_resp_valid = '1;
            repeat (2) begin
               @(negedge clk);
               check_outputs("in_reset");
            end
            reset = 1'b0;
         end
         drive(cyc >= 1000 && cyc < 2000 ? 15 : 80);
         model_step();
      end
      @(negedge clk);
      check_outputs("final");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
